// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default reset values,
// opcode field position and the fetch FSM state encoding.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } if_state_e;

    function automatic logic [5:0] op_field(input logic [31:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: loads when enabled, clear-to-bubble has priority.
// PCPLUS4 is left untouched by a bubble; only the instruction and valid flag drop.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pcplus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pcplus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pcplus4_q;
    logic        valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q   <= NOP_INSTR;
            pcplus4_q <= 32'h0;
            valid_q   <= 1'b0;
        end else if (clr_i) begin
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
        end else if (en_i) begin
            instr_q   <= instr_i;
            pcplus4_q <= pcplus4_i;
            valid_q   <= 1'b1;
        end
    end

    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// req/ready port, parks words during stalls and drains stale fetches on redirect.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALLD,
    input  logic        PCSRCD,
    input  logic [31:0] PCBRANCHD,
    input  logic        JMPD,
    input  logic [25:0] JADDRD,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_RDATA,
    input  logic        IMEM_READY,
    output logic [31:0] INSTRD,
    output logic [5:0]  OPD,
    output logic [31:0] PCPLUS4D,
    output logic        VALIDD
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] ld_instr;
    logic        redirect;
    logic        done;
    logic        clr;

    assign pc_plus4  = pc_q + 32'd4;
    assign redirect  = (PCSRCD | JMPD) & ~STALLD;
    assign target    = JMPD ? {PCPLUS4D[31:28], JADDRD, 2'b00} : (PCBRANCHD & 32'hFFFF_FFFC);
    assign IMEM_REQ  = ~RST & (state_q != ST_HOLD);
    assign IMEM_ADDR = pc_q;
    assign done      = IMEM_REQ & IMEM_READY;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        skid_d   = skid_q;
        tgt_d    = tgt_q;
        clr      = 1'b0;
        ld_instr = IMEM_RDATA;
        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    clr = 1'b1;
                    if (done) begin
                        pc_d = target;
                    end else begin
                        tgt_d   = target;
                        state_d = ST_DRAIN;
                    end
                end else if (STALLD) begin
                    if (done) begin
                        skid_d  = IMEM_RDATA;
                        state_d = ST_HOLD;
                    end
                end else if (done) begin
                    pc_d = pc_plus4;
                end else begin
                    clr = 1'b1;
                end
            end
            ST_HOLD: begin
                ld_instr = skid_q;
                if (redirect) begin
                    clr     = 1'b1;
                    pc_d    = target;
                    state_d = ST_FETCH;
                end else if (!STALLD) begin
                    pc_d    = pc_plus4;
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // Address stays at the old PC until the stale response lands;
                // the newest redirect always wins.
                clr = 1'b1;
                if (redirect) begin
                    tgt_d = target;
                end
                if (done) begin
                    pc_d    = redirect ? target : tgt_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                clr     = 1'b1;
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            skid_q  <= 32'h0;
            tgt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
            tgt_q   <= tgt_d;
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk_i     (CLK),
        .rst_i     (RST),
        .en_i      (~STALLD),
        .clr_i     (clr),
        .instr_i   (ld_instr),
        .pcplus4_i (pc_plus4),
        .instr_o   (INSTRD),
        .pcplus4_o (PCPLUS4D),
        .valid_o   (VALIDD)
    );

    assign OPD = op_field(INSTRD);

endmodule
